// File: rtl/cpu_pkg.sv
// Shared fetch-side types: address/data widths, fetch FSM states, buffer entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch bus: instruction-memory read port plus the decode valid/ready handshake.
// Latency: n/a (wires only); mem_data answers mem_addr in the same cycle.
// Backpressure: ir_ready from the decode side stalls the instruction stream.
interface inst_fetch_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              ir_valid;
  logic              ir_ready;
  logic [DATA_W-1:0] ir_out;
  logic [ADDR_W-1:0] pc_out;

  // Fetch unit side.
  modport master (
    output mem_addr, ir_valid, ir_out, pc_out,
    input  mem_data, ir_ready
  );

  // Memory + decode side.
  modport slave (
    input  mem_addr, ir_valid, ir_out, pc_out,
    output mem_data, ir_ready
  );
endinterface

// File: rtl/inst_fetch_buf.sv
// Two-entry instruction buffer of {pc, instr} with push, pop and flush.
// Latency: a pushed entry is visible at head one cycle after the push edge.
// Backpressure: caller must not push when full unless popping the same cycle.
module fetch_buf
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t ent0;
  fetch_entry_t ent1;
  logic [1:0]   cnt;

  // Shift-register storage: ent0 is always the head, ent1 the second slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= push_dat;
          else             ent1 <= push_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= push_dat;
          end else begin
            ent0 <= ent1;
            ent1 <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = cnt;
  assign head  = ent0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC + FSM drive instruction memory, buffer feeds decode.
// Latency: start/redirect at edge t -> instruction valid after edge t+1; 1/cycle steady.
// Backpressure: full buffer with ir_ready low freezes pc, buffer and mem_addr.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256  // widths ADDR_W/DATA_W come from cpu_pkg
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  inst_fetch_if.master      bus,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              push, pop, flush;
  logic [1:0]        count, cnt_nxt;
  fetch_entry_t      head;
  fetch_entry_t      push_dat;

  assign pop      = bus.ir_valid & bus.ir_ready;
  assign push_dat = '{pc: pc, instr: bus.mem_data};

  fetch_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (flush),
    .count    (count),
    .head     (head)
  );

  // Next state, next pc and buffer controls. Targets at or past DEPTH park
  // pc at DEPTH so it never runs beyond the end of memory.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_nxt    = (start_pc >= LIMIT) ? LIMIT : start_pc;
          state_nxt = (start_pc >= LIMIT) ? DONE : RUN;
        end
      end
      RUN: begin
        if (redirect) begin
          flush     = 1'b1;
          pc_nxt    = (redirect_pc >= LIMIT) ? LIMIT : redirect_pc;
          state_nxt = (redirect_pc >= LIMIT) ? DONE : RUN;
        end else if (count != 2'd2 || pop) begin
          push   = 1'b1;
          pc_nxt = pc + ADDR_W'(1);
          if (pc == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        if (redirect) begin
          flush     = 1'b1;
          pc_nxt    = (redirect_pc >= LIMIT) ? LIMIT : redirect_pc;
          state_nxt = (redirect_pc >= LIMIT) ? DONE : RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase

    cnt_nxt = count;
    if (flush)             cnt_nxt = 2'd0;
    else if (push && !pop) cnt_nxt = count + 2'd1;
    else if (pop && !push) cnt_nxt = count - 2'd1;
  end

  // State, pc and halted registers; halted tracks the post-edge state/count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      halted <= (state_nxt == DONE) && (cnt_nxt == 2'd0);
    end
  end

  assign bus.mem_addr = pc;
  assign bus.ir_valid = (count != 2'd0);
  assign bus.ir_out   = head.instr;
  assign bus.pc_out   = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then randomized traffic vs a queue model.
// Latency: model advances once per clock edge, outputs compared 1 time unit later.
// Backpressure: ir_ready is driven low in directed steps and randomly afterwards.
module tb_inst_fetch;
  import cpu_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset, start, redirect, halted;
  logic [15:0] start_pc, redirect_pc;
  logic [31:0] mem [DEPTH];
  logic [31:0] prog [4];

  inst_fetch_if bus();

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_pc    (start_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = (bus.mem_addr < 16'(DEPTH)) ? mem[bus.mem_addr[7:0]] : 32'h0;

  // Reference model: state 0=idle 1=run 2=done, a pc and a queue of pending instructions.
  typedef struct {
    int          pc;
    logic [31:0] ins;
  } ment_t;

  int    m_state;
  int    m_pc;
  ment_t mq[$];
  bit    m_zero;
  bit    m_halted;

  logic [15:0] log_pc[$];
  logic [31:0] log_ins[$];

  int checks = 0;
  int errors = 0;
  bit seen_pc1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit do_pop;
    if (!reset) begin
      m_state = 0;
      m_pc    = 0;
      mq.delete();
      m_zero  = 1'b1;
    end else begin
      do_pop = (mq.size() > 0) && bus.ir_ready;
      if (m_state == 0) begin
        if (start) begin
          m_pc    = (start_pc >= DEPTH) ? DEPTH : int'(start_pc);
          m_state = (start_pc >= DEPTH) ? 2 : 1;
        end
      end else if (redirect) begin
        mq.delete();
        m_pc    = (redirect_pc >= DEPTH) ? DEPTH : int'(redirect_pc);
        m_state = (redirect_pc >= DEPTH) ? 2 : 1;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (m_state == 1 && mq.size() < 2) begin
          mq.push_back('{pc: m_pc, ins: mem[m_pc]});
          m_zero = 1'b0;
          m_pc++;
          if (m_pc == DEPTH) m_state = 2;
        end
      end
    end
    m_halted = (m_state == 2) && (mq.size() == 0);
  endtask

  // One clock: log what decode takes, advance model, then compare after the edge.
  task automatic step();
    if (reset === 1'b1 && bus.ir_valid === 1'b1 && bus.ir_ready === 1'b1) begin
      log_pc.push_back(bus.pc_out);
      log_ins.push_back(bus.ir_out);
    end
    model_step();
    @(posedge clk);
    #1;
    chk("ir_valid", bus.ir_valid, mq.size() != 0);
    chk("mem_addr", bus.mem_addr, m_pc);
    chk("halted", halted, m_halted);
    if (mq.size() != 0) begin
      chk("ir_out", bus.ir_out, mq[0].ins);
      chk("pc_out", bus.pc_out, mq[0].pc);
    end else if (m_zero) begin
      chk("ir_out_zero", bus.ir_out, 0);
      chk("pc_out_zero", bus.pc_out, 0);
    end
  endtask

  initial begin
    prog[0] = 32'h6842000A;
    prog[1] = 32'h6885FFF0;
    prog[2] = 32'h48C81100;
    prog[3] = 32'h0FC64000;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = prog[i];

    reset = 1'b0; start = 1'b0; redirect = 1'b0; bus.ir_ready = 1'b0;
    start_pc = 16'd0; redirect_pc = 16'd0;
    step();
    step();
    chk("rst_mem_addr", bus.mem_addr, 0);

    // Straight-line program at full rate.
    reset = 1'b1; start = 1'b1; start_pc = 16'd0; bus.ir_ready = 1'b1;
    step();
    chk("t1_first_valid_low", bus.ir_valid, 0);
    start = 1'b0;
    log_pc.delete(); log_ins.delete();
    repeat (5) step();
    chk("t1_count", log_pc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pc", log_pc[i], i);
      chk("t1_ins", log_ins[i], prog[i]);
    end

    // Backpressure: buffer fills to two and freezes.
    reset = 1'b0; step();
    reset = 1'b1; start = 1'b1; bus.ir_ready = 1'b0;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("t2_mem_addr_hold", bus.mem_addr, 2);
    chk("t2_head_hold", bus.ir_out, prog[0]);
    log_pc.delete(); log_ins.delete();
    bus.ir_ready = 1'b1;
    repeat (3) step();
    chk("t2_count", log_pc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_pc", log_pc[i], i);
      chk("t2_ins", log_ins[i], prog[i]);
    end

    // Redirect with a full buffer while decode takes the head.
    reset = 1'b0; step();
    reset = 1'b1; start = 1'b1; bus.ir_ready = 1'b0;
    step();
    start = 1'b0;
    repeat (3) step();
    log_pc.delete(); log_ins.delete();
    bus.ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    repeat (3) step();
    chk("t3_consumed_head", log_pc[0], 0);
    chk("t3_first_after", log_pc[1], 16'h0040);
    chk("t3_second_after", log_pc[2], 16'h0041);
    seen_pc1 = 1'b0;
    foreach (log_pc[i]) if (log_pc[i] == 16'd1) seen_pc1 = 1'b1;
    chk("t3_flushed_never_seen", seen_pc1, 0);

    // Reset mid-run with a full buffer; start/redirect must not leak through.
    bus.ir_ready = 1'b0;
    repeat (2) step();
    chk("t5_full_before", bus.ir_valid, 1);
    reset = 1'b0; start = 1'b1; redirect = 1'b1; redirect_pc = 16'd5;
    step();
    chk("t5_valid", bus.ir_valid, 0);
    chk("t5_ir_out", bus.ir_out, 0);
    chk("t5_pc_out", bus.pc_out, 0);
    chk("t5_mem_addr", bus.mem_addr, 0);
    step();
    reset = 1'b1; start = 1'b0;
    step();
    chk("t5_idle_redirect_ignored", bus.mem_addr, 0);
    redirect = 1'b0;

    // End of memory: halt, park at DEPTH, then resume by redirect.
    start = 1'b1; start_pc = 16'd254; bus.ir_ready = 1'b1;
    step();
    start = 1'b0;
    log_pc.delete(); log_ins.delete();
    for (int i = 0; i < 20 && halted !== 1'b1; i++) step();
    chk("t4_halted", halted, 1);
    chk("t4_count", log_pc.size(), 2);
    chk("t4_pc0", log_pc[0], 254);
    chk("t4_pc1", log_pc[1], 255);
    chk("t4_ins1", log_ins[1], mem[255]);
    repeat (2) step();
    chk("t4_mem_addr_park", bus.mem_addr, 256);
    redirect = 1'b1; redirect_pc = 16'd0;
    step();
    redirect = 1'b0;
    chk("t4_halt_clear", halted, 0);
    step();
    chk("t4_resume_valid", bus.ir_valid, 1);
    chk("t4_resume_pc", bus.pc_out, 0);

    // Redirect beyond memory while running.
    redirect = 1'b1; redirect_pc = 16'd300;
    step();
    redirect = 1'b0;
    chk("t6_halted", halted, 1);
    chk("t6_valid", bus.ir_valid, 0);
    chk("t6_mem_addr", bus.mem_addr, 256);
    step();
    chk("t6_no_push", bus.ir_valid, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 199) != 0);
      start        = ($urandom_range(0, 3) == 0);
      start_pc     = 16'($urandom_range(0, DEPTH - 1));
      redirect     = ($urandom_range(0, 15) == 0);
      redirect_pc  = 16'($urandom_range(0, 300));
      bus.ir_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
